// File: rtl/ff_input_cond_if.sv
// Switch-input bundle between the cabinet pins and the game core.
// The conditioning block takes the slave side; whoever drives the pins takes master.
interface ff_input_cond_if #(
    parameter int N_CH = 10
);
    logic [N_CH-1:0] i_sw;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_rise;
    logic [N_CH-1:0] o_fall;
    logic [N_CH-1:0] o_pulse;

    modport master (
        output i_sw,
        input  o_level,
        input  o_rise,
        input  o_fall,
        input  o_pulse
    );

    modport slave (
        input  i_sw,
        output o_level,
        output o_rise,
        output o_fall,
        output o_pulse
    );
endinterface

// File: rtl/ff_input_cond.sv
// Cabinet control conditioning: per-channel 2-flop sync, optional inversion,
// counter debounce, and registered level / edge strobes / fixed-length pulses.
module ff_input_cond #(
    parameter int              N_CH            = 10,
    parameter int              DEBOUNCE_CYCLES = 12000,
    parameter int              CNT_W           = 14,
    parameter logic [N_CH-1:0] INVERT          = {N_CH{1'b0}},
    parameter logic [N_CH-1:0] PULSE_MASK      = {N_CH{1'b0}},
    parameter int              PULSE_LEN       = 4,
    parameter int              PLS_W           = 3
) (
    input  logic           clk12m,
    input  logic           reset,
    ff_input_cond_if.slave sw_if
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PLS_W-1:0] PLS_MAX = PLS_W'(PULSE_LEN - 1);

    logic [N_CH-1:0]  r_sync_p0;
    logic [N_CH-1:0]  r_sync_p1;
    logic [N_CH-1:0]  r_stable;
    logic [N_CH-1:0]  r_rise;
    logic [N_CH-1:0]  r_fall;
    logic [N_CH-1:0]  r_pulse;
    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [PLS_W-1:0] r_pcnt [N_CH];

    logic [N_CH-1:0]  w_v;
    logic [N_CH-1:0]  w_accept;

    // Inversion happens after the synchroniser, so inverted channels leave reset reading 1.
    assign w_v = r_sync_p1 ^ INVERT;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_accept[i] = (w_v[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Stage p0 -> p1: metastability chain, then the accepted level and its edges.
    always_ff @(posedge clk12m or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_stable  <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
        end else begin
            r_sync_p0 <= sw_if.i_sw;
            r_sync_p1 <= r_sync_p0;
            r_stable  <= r_stable ^ w_accept;
            r_rise    <= w_accept & w_v;
            r_fall    <= w_accept & ~w_v;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the window.
    always_ff @(posedge clk12m or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_v[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A running pulse ignores further rises; it is neither retriggered nor stretched.
    always_ff @(posedge clk12m or negedge reset) begin
        if (!reset) begin
            r_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_pcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (!PULSE_MASK[i]) begin
                    r_pulse[i] <= 1'b0;
                    r_pcnt[i]  <= '0;
                end else if (r_pulse[i]) begin
                    if (r_pcnt[i] == '0) begin
                        r_pulse[i] <= 1'b0;
                    end else begin
                        r_pcnt[i] <= r_pcnt[i] - PLS_W'(1);
                    end
                end else if (w_accept[i] && w_v[i]) begin
                    r_pulse[i] <= 1'b1;
                    r_pcnt[i]  <= PLS_MAX;
                end
            end
        end
    end

    assign sw_if.o_level = r_stable;
    assign sw_if.o_rise  = r_rise;
    assign sw_if.o_fall  = r_fall;
    assign sw_if.o_pulse = r_pulse;

endmodule

// File: tb/tb_ff_input_cond.sv
// Bench for ff_input_cond: a DEBOUNCE_CYCLES=4 build driven from a cycle table,
// plus a DEBOUNCE_CYCLES=1 build for the pulse no-retrigger case.
module tb_ff_input_cond;

  typedef struct {
    string      tag;
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pls;
  } vec_t;

  logic clk12m = 1'b0;
  logic reset;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  string cur_tag;
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk12m = ~clk12m;

  ff_input_cond_if #(.N_CH(4)) bus4 ();
  ff_input_cond_if #(.N_CH(4)) bus1 ();

  ff_input_cond #(
    .N_CH(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .INVERT(4'b0100),
    .PULSE_MASK(4'b0001), .PULSE_LEN(3), .PLS_W(2)
  ) u_dut (
    .clk12m(clk12m),
    .reset (reset),
    .sw_if (bus4)
  );

  ff_input_cond #(
    .N_CH(4), .DEBOUNCE_CYCLES(1), .CNT_W(1), .INVERT(4'b0100),
    .PULSE_MASK(4'b0001), .PULSE_LEN(3), .PLS_W(2)
  ) u_dut_d1 (
    .clk12m(clk12m),
    .reset (reset),
    .sw_if (bus1)
  );

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic rows(input int n, input logic [3:0] sw, input logic [3:0] lvl,
                      input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] pls);
    vec_t v;
    v.tag = cur_tag; v.sw = sw; v.lvl = lvl; v.rise = rise; v.fall = fall; v.pls = pls;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " level"}, bus4.o_level, 4'b0000);
    check({name, " rise"},  bus4.o_rise,  4'b0000);
    check({name, " fall"},  bus4.o_fall,  4'b0000);
    check({name, " pulse"}, bus4.o_pulse, 4'b0000);
  endtask

  // Row k's input is sampled at edge k of the segment; outputs are read 1 ns after that edge.
  task automatic apply_table();
    vec_t e;
    for (int k = 0; k < tbl.size(); k++) begin
      bus4.i_sw = tbl[k].sw;
      exp_q.push_back(tbl[k]);
      @(posedge clk12m); #1;
      e = exp_q.pop_front();
      check($sformatf("%s row%0d level", e.tag, k + 1), bus4.o_level, e.lvl);
      check($sformatf("%s row%0d rise",  e.tag, k + 1), bus4.o_rise,  e.rise);
      check($sformatf("%s row%0d fall",  e.tag, k + 1), bus4.o_fall,  e.fall);
      check($sformatf("%s row%0d pulse", e.tag, k + 1), bus4.o_pulse, e.pls);
      check($sformatf("%s row%0d rise&fall", e.tag, k + 1), bus4.o_rise & bus4.o_fall, 4'b0000);
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t d1_tbl[7];
    vec_t e;
    int   pulse_cycles;

    reset     = 1'b0;
    bus4.i_sw = 4'b0100;
    bus1.i_sw = 4'b0000;
    repeat (3) @(posedge clk12m);
    #1;
    check_all_zero("reset_state");
    reset = 1'b1;

    // Clean press on ch0 with the inverted ch2 pin idle-high
    cur_tag = "clean_press";
    rows(5, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "glitch_3cyc";
    rows(3, 4'b0111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rows(5, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "hold_4cyc";
    rows(4, 4'b0111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    rows(3, 4'b0101, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0000, 4'b0010, 4'b0000);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "invert_press";
    rows(5, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0001, 4'b0101, 4'b0100, 4'b0000, 4'b0000);
    rows(2, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "invert_release";
    rows(5, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0000);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "ch0_release";
    rows(5, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    rows(2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    cur_tag = "simul_rise";
    rows(5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b1111, 4'b1011, 4'b1011, 4'b0000, 4'b0001);
    rows(2, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 4'b0001);
    apply_table();

    cur_tag = "simul_fall";
    rows(5, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0000);
    rows(2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    // Single-cycle debounce build: second rise lands while the pulse is still high
    d1_tbl[0] = '{"no_retrig", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    d1_tbl[1] = '{"no_retrig", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    d1_tbl[2] = '{"no_retrig", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    d1_tbl[3] = '{"no_retrig", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    d1_tbl[4] = '{"no_retrig", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    d1_tbl[5] = '{"no_retrig", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    d1_tbl[6] = '{"no_retrig", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    pulse_cycles = 0;
    for (int k = 0; k < 7; k++) begin
      bus1.i_sw = d1_tbl[k].sw;
      exp_q.push_back(d1_tbl[k]);
      @(posedge clk12m); #1;
      e = exp_q.pop_front();
      check($sformatf("%s row%0d level", e.tag, k + 1), {3'b000, bus1.o_level[0]}, e.lvl);
      check($sformatf("%s row%0d rise",  e.tag, k + 1), {3'b000, bus1.o_rise[0]},  e.rise);
      check($sformatf("%s row%0d fall",  e.tag, k + 1), {3'b000, bus1.o_fall[0]},  e.fall);
      check($sformatf("%s row%0d pulse", e.tag, k + 1), {3'b000, bus1.o_pulse[0]}, e.pls);
      if (bus1.o_pulse[0] === 1'b1) pulse_cycles++;
    end
    check("no_retrig pulse_cycles", pulse_cycles[3:0], 4'd3);
    bus1.i_sw = 4'b0000;

    // Reset while the ch0 debounce counter sits at 2
    cur_tag = "rst_dbnc_pre";
    rows(4, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    apply_table();
    reset = 1'b0;
    #1;
    check_all_zero("rst_dbnc_async");
    check("rst_dbnc_async d1 level", bus1.o_level, 4'b0000);
    repeat (2) @(posedge clk12m);
    #1;
    reset = 1'b1;

    cur_tag = "rst_dbnc_restart";
    rows(5, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    rows(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    apply_table();

    // Now in the pulse's 2nd high cycle
    reset = 1'b0;
    #1;
    check_all_zero("rst_pulse_async");
    repeat (2) @(posedge clk12m);
    #1;
    reset = 1'b1;

    cur_tag = "rst_pulse_restart";
    rows(5, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rows(1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    rows(2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    apply_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_input_cond.md
Name: ff_input_cond

Overview:
- Parametrised input-conditioning block for the cabinet controls: player buttons, coins, start, test and the centre switches.
- Sits between the board switch pins and the game core.
- Per channel it does four things:
  - synchronises the raw input;
  - applies an optional polarity inversion;
  - debounces over a programmable window;
  - produces level, edge and fixed-length pulse outputs. Pulse outputs are used for coin counters and credit logic.
- Channel count, debounce window and pulse length are all parameters, so one block serves every control group.

Parameters:
- N_CH, 10, number of input channels.
- DEBOUNCE_CYCLES, 12000, cycles an input must hold a new value before it is accepted (1 ms at 12 MHz). Must be ≥1.
- CNT_W, 14, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- INVERT, {N_CH{1'b0}}, per-channel mask. Bit set means the raw input is active-low and is inverted after synchronisation.
- PULSE_MASK, {N_CH{1'b0}}, per-channel mask. Bit set enables the o_pulse generator for that channel.
- PULSE_LEN, 4, o_pulse high time in cycles. Must be ≥1.
- PLS_W, 3, pulse counter width. Must satisfy 2^PLS_W > PULSE_LEN-1.

Ports:
- clk12m, input, 1, system clock (12 MHz).
- reset, input, 1, asynchronous, active-low. All state clears while low.
- i_sw, input, N_CH, raw asynchronous switch inputs.
- o_level, output, N_CH, debounced, polarity-corrected level.
- o_rise, output, N_CH, one-cycle strobe when o_level goes 0→1.
- o_fall, output, N_CH, one-cycle strobe when o_level goes 1→0.
- o_pulse, output, N_CH, PULSE_LEN-cycle pulse started by each rise. Driven only on channels set in PULSE_MASK, else held at 0.

Behaviour:
- Reset (reset low, asynchronous): the following all clear to 0, including mid-operation:
  - sync flops, debounce counters, stable state;
  - o_level, o_rise, o_fall, o_pulse;
  - pulse counters.
  - After release, the first edge samples normally.
- Synchroniser: a 2-flop chain per channel. v[i] = sync2[i] ^ INVERT[i]. Because sync flops reset to 0, an INVERT channel starts with v=1 and debounces to o_level=1 after the window (an idle active-low switch reads pressed=0 only if the pin is high; that is the intended mapping).
- Debounce, per channel, on each clock edge:
  - If v == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← v and counter ← 0.
  - Else: counter ← counter+1.
- o_level = stable, registered.
- Latency: if a raw change is first sampled at edge 1 and then held, o_level changes at edge DEBOUNCE_CYCLES+2.
- A glitch that lasts fewer than DEBOUNCE_CYCLES cycles after sync produces no output change.
- Edges: o_rise[i] / o_fall[i] are registered. Each is high exactly in the cycle where o_level[i] first shows its new value. Both are 0 in all other cycles, and they are never high together.
- Pulse generator (PULSE_MASK[i] = 1):
  - On o_rise (the same edge that updates stable), o_pulse[i] ← 1 and pcnt ← PULSE_LEN-1.
  - While high, pcnt decrements each cycle. o_pulse drops on the edge after pcnt reaches 0, giving exactly PULSE_LEN high cycles.
  - A rise arriving while o_pulse is high is ignored: no retrigger, no extension.
  - o_fall does not affect the pulse.
- Channels are fully independent. Simultaneous changes on any set of channels are each handled in parallel, with identical latency.
- Counters never wrap: the debounce counter is bounded by DEBOUNCE_CYCLES-1 and the pulse counter by PULSE_LEN-1.

Test Plan (bench parameters: N_CH=4, DEBOUNCE_CYCLES=4, PULSE_LEN=3, INVERT=4'b0100, PULSE_MASK=4'b0001):

1. Clean press:
   - Stimulus: hold reset low 3 cycles, release; i_sw=4'b0100, then ch0 0→1 sampled at edge 1.
   - Required: o_level[0]=1 at edge 6; o_rise[0]=1 for that single cycle; o_pulse[0] high exactly 3 cycles starting edge 6.
2. Glitch rejection:
   - Stimulus: ch1 high for 3 cycles, then low.
   - Required: o_level[1], o_rise[1], o_fall[1] stay 0.
   - Stimulus: ch1 high for 4 cycles.
   - Required: o_level[1]=1 at edge 6.
3. Inversion:
   - Stimulus: ch2 pin held 1 from reset.
   - Required: o_level[2] stays 0.
   - Stimulus: pin→0.
   - Required: o_level[2]=1 after 6 edges; o_pulse[2] stays 0 (not in mask).
4. No retrigger:
   - Stimulus: ch0 rises, then falls and rises again so that the second o_rise[0] lands inside the 3-cycle pulse (use DEBOUNCE_CYCLES=1 build).
   - Required: o_pulse[0] high exactly 3 cycles total; second o_rise[0] still strobes.
5. Simultaneous + release:
   - Stimulus: ch0, ch1, ch3 rise on the same edge; later all fall together.
   - Required: o_rise=4'b1011 in one cycle; later o_fall=4'b1011 in one cycle; identical latency.
6. Reset mid-operation:
   - Stimulus: assert reset during debounce count 2 and during the pulse's 2nd cycle.
   - Required: all outputs 0 immediately (asynchronously).
   - Stimulus: after release with the input held.
   - Required: full 6-edge latency restarts.
